// File: rtl/irrigacao_pkg.sv
// Shared state codes and default timing constants for the drip-irrigation valve stage.
package irrigacao_pkg;

  typedef enum logic [1:0] {
    FECHADA = 2'd0,
    FILTRO  = 2'd1,
    ABERTA  = 2'd2,
    PAUSA   = 2'd3
  } estado_t;

  localparam int DEB_TICKS_DEF = 3;
  localparam int MIN_ON_DEF    = 10;
  localparam int MAX_ON_DEF    = 600;
  localparam int MIN_OFF_DEF   = 30;
  localparam int CW_DEF        = 10;

endpackage

// File: rtl/contador_ticks.sv
// Tick counter with synchronous clear, tick enable and a terminal-value compare.
module contador_ticks #(
  parameter int CW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic [CW-1:0] lim,
  output logic [CW-1:0] cnt,
  output logic          fim
);

  always_ff @(posedge clk) begin
    if (rst || clr)
      cnt <= '0;
    else if (en)
      cnt <= cnt + CW'(1);
  end

  assign fim = (cnt == lim);

endmodule

// File: rtl/valvula_gotejamento.sv
// Solenoid valve actuator: debounce, min on/off time and max-on watchdog.
// Optional open-cycle counter on port ciclos when CONTADOR_CICLOS_EN is defined.
module valvula_gotejamento
  import irrigacao_pkg::*;
#(
  parameter int DEB_TICKS = DEB_TICKS_DEF,
  parameter int MIN_ON    = MIN_ON_DEF,
  parameter int MAX_ON    = MAX_ON_DEF,
  parameter int MIN_OFF   = MIN_OFF_DEF,
  parameter int CW        = CW_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       req,
  input  logic       alin,
  output logic       valvula,
  output logic [1:0] estado,
  output logic       falha
`ifdef CONTADOR_CICLOS_EN
  ,
  output logic [7:0] ciclos
`endif
);

  estado_t       state_q, state_d;
  logic          drop_q;
  logic          set_falha;
  logic          cnt_clr, cnt_en, fim;
  logic [CW-1:0] cnt, lim;
  logic          fecha_req;

  contador_ticks #(.CW(CW)) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (cnt_en),
    .lim (lim),
    .cnt (cnt),
    .fim (fim)
  );

  always_comb begin
    lim = '0;
    case (state_q)
      FILTRO:  lim = CW'(DEB_TICKS - 1);
      ABERTA:  lim = CW'(MAX_ON - 1);
      PAUSA:   lim = CW'(MIN_OFF - 1);
      default: lim = '0;
    endcase
  end

  // A request drop seen before MIN_ON is remembered in drop_q until the valve closes.
  assign fecha_req = (~req | drop_q) && (cnt >= CW'(MIN_ON));

  always_comb begin
    state_d   = state_q;
    set_falha = 1'b0;
    case (state_q)
      FECHADA: if (req && !alin) state_d = FILTRO;
      FILTRO: begin
        if (!req || alin)     state_d = FECHADA;
        else if (tick && fim) state_d = ABERTA;
      end
      ABERTA: begin
        if (alin) state_d = PAUSA;
        else if (tick && fim) begin
          state_d   = PAUSA;
          set_falha = 1'b1;
        end
        else if (fecha_req) state_d = PAUSA;
      end
      PAUSA:   if (tick && fim) state_d = FECHADA;
      default: state_d = FECHADA;
    endcase
  end

  assign cnt_clr = (state_d != state_q);
  assign cnt_en  = tick && (state_q != FECHADA);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FECHADA;
      valvula <= 1'b0;
      falha   <= 1'b0;
      drop_q  <= 1'b0;
    end
    else begin
      state_q <= state_d;
      valvula <= (state_d == ABERTA);
      falha   <= falha | set_falha;
      drop_q  <= (state_q == ABERTA) && (state_d == ABERTA) && (drop_q || !req);
    end
  end

  assign estado = state_q;

`ifdef CONTADOR_CICLOS_EN
  always_ff @(posedge clk) begin
    if (rst)
      ciclos <= 8'd0;
    else if (state_q == ABERTA && state_d == PAUSA && ciclos != 8'hFF)
      ciclos <= ciclos + 8'd1;
  end
`endif

endmodule

// File: tb/tb_valvula_gotejamento.sv
// Self-checking bench for valvula_gotejamento: directed scenarios plus random traffic vs a reference model.
module tb_valvula_gotejamento;

  localparam int DEB    = 3;
  localparam int MINON  = 4;
  localparam int MAXON  = 8;
  localparam int MINOFF = 5;
  localparam int CW     = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       req = 1'b0;
  logic       alin = 1'b0;
  logic       valvula;
  logic [1:0] estado;
  logic       falha;
`ifdef CONTADOR_CICLOS_EN
  logic [7:0] ciclos;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: mode 0 closed, 1 debouncing, 2 open, 3 resting.
  int mode = 0;
  int ticks_in_mode = 0;
  bit dropped = 0;
  int m_falha = 0;
  int m_ciclos = 0;

  valvula_gotejamento #(
    .DEB_TICKS(DEB), .MIN_ON(MINON), .MAX_ON(MAXON), .MIN_OFF(MINOFF), .CW(CW)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .req(req), .alin(alin),
    .valvula(valvula), .estado(estado), .falha(falha)
`ifdef CONTADOR_CICLOS_EN
    , .ciclos(ciclos)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic modelEdge(input bit r, input bit q, input bit a, input bit t);
    int nxt;
    if (r) begin
      mode = 0; ticks_in_mode = 0; dropped = 0; m_falha = 0; m_ciclos = 0;
      return;
    end
    nxt = mode;
    case (mode)
      0: if (q && !a) nxt = 1;
      1: if (!q || a) nxt = 0; else if (t && ticks_in_mode + 1 == DEB) nxt = 2;
      2: begin
        if (a) nxt = 3;
        else if (t && ticks_in_mode + 1 == MAXON) begin nxt = 3; m_falha = 1; end
        else if ((!q || dropped) && ticks_in_mode >= MINON) nxt = 3;
      end
      default: if (t && ticks_in_mode + 1 == MINOFF) nxt = 0;
    endcase
    if (nxt != mode) begin
      if (mode == 2 && m_ciclos < 255) m_ciclos++;
      mode = nxt; ticks_in_mode = 0; dropped = 0;
    end
    else begin
      if (t && mode != 0) ticks_in_mode++;
      if (mode == 2 && !q) dropped = 1;
    end
  endtask

  task automatic applyStimulus(input bit r, input bit q, input bit a);
    rst = r; req = q; alin = a;
    tick = ((cyc % 4) == 3);
    @(posedge clk);
    modelEdge(r, q, a, tick);
    cyc++;
    #1;
    checkOutput("estado", estado, mode);
    checkOutput("valvula", valvula, (mode == 2));
    checkOutput("falha", falha, m_falha);
`ifdef CONTADOR_CICLOS_EN
    checkOutput("ciclos", ciclos, m_ciclos);
`endif
  endtask

  task automatic runCycle();
    for (int k = 0; k < 200 && mode != 2; k++) applyStimulus(0, 1, 0);
    for (int k = 0; k < 200 && mode != 0; k++) applyStimulus(0, 0, 0);
    checkOutput("cycle_done", estado, 0);
  endtask

  int open_ticks;
  int pause_ticks;
  bit saw_open;

  initial begin
    // Reset held with req high
    repeat (3) applyStimulus(1, 1, 0);
    checkOutput("rst_estado", estado, 0);
    checkOutput("rst_valvula", valvula, 0);
    checkOutput("rst_falha", falha, 0);
    applyStimulus(0, 1, 0);
    checkOutput("post_rst_filtro", estado, 1);

    // Debounce: two ticks then drop
    for (int k = 0; k < 50 && !(mode == 1 && ticks_in_mode == 2); k++) applyStimulus(0, 1, 0);
    applyStimulus(0, 0, 0);
    checkOutput("deb_abort", estado, 0);
    checkOutput("deb_abort_valv", valvula, 0);

    saw_open = 0;
    for (int k = 0; k < 50 && mode != 2; k++) begin
      applyStimulus(0, 1, 0);
      if (valvula) saw_open = 1;
    end
    checkOutput("deb_open", estado, 2);
    checkOutput("deb_open_on_tick", tick, 1);

    // Minimum on-time: drop after one tick, must hold until MIN_ON ticks
    for (int k = 0; k < 50 && ticks_in_mode < 1; k++) applyStimulus(0, 1, 0);
    open_ticks = 1;
    for (int k = 0; k < 100 && mode == 2; k++) begin
      applyStimulus(0, 0, 0);
      if (tick && mode == 2) open_ticks++;
    end
    checkOutput("min_on_ticks", open_ticks, MINON);
    checkOutput("min_on_pausa", estado, 3);
    pause_ticks = 0;
    for (int k = 0; k < 100 && mode == 3; k++) begin
      applyStimulus(0, 1, 0);
      if (tick) pause_ticks++;
    end
    checkOutput("min_off_ticks", pause_ticks, MINOFF);
    checkOutput("min_off_fechada", estado, 0);

    // Watchdog
    applyStimulus(1, 0, 0);
    for (int k = 0; k < 50 && mode != 2; k++) applyStimulus(0, 1, 0);
    open_ticks = 0;
    for (int k = 0; k < 200 && mode == 2; k++) begin
      applyStimulus(0, 1, 0);
      if (tick) open_ticks++;
    end
    checkOutput("wdog_ticks", open_ticks, MAXON);
    checkOutput("wdog_falha", falha, 1);
    checkOutput("wdog_estado", estado, 3);
    runCycle();
    checkOutput("wdog_sticky", falha, 1);
    applyStimulus(1, 0, 0);
    checkOutput("wdog_cleared", falha, 0);

    // Alarm at cnt=1 closes at once
    for (int k = 0; k < 50 && mode != 2; k++) applyStimulus(0, 1, 0);
    for (int k = 0; k < 50 && ticks_in_mode < 1; k++) applyStimulus(0, 1, 0);
    applyStimulus(0, 1, 1);
    checkOutput("alin_valv", valvula, 0);
    checkOutput("alin_estado", estado, 3);
    for (int k = 0; k < 100 && mode != 0; k++) applyStimulus(0, 0, 0);

    // Alarm on the watchdog tick: no fault
    for (int k = 0; k < 50 && mode != 2; k++) applyStimulus(0, 1, 0);
    for (int k = 0; k < 200 && !(mode == 2 && ticks_in_mode == MAXON - 1 && (cyc % 4) == 3); k++)
      applyStimulus(0, 1, 0);
    applyStimulus(0, 1, 1);
    checkOutput("alin_wdog_estado", estado, 3);
    checkOutput("alin_wdog_falha", falha, 0);

    // Random traffic against the model
    applyStimulus(1, 0, 0);
    for (int i = 0; i < 4000; i++) begin
      bit r, q, a;
      r = ($urandom_range(0, 699) == 0);
      a = ($urandom_range(0, 39) == 0);
      q = ($urandom_range(0, 7) == 0) ? ~req : req;
      applyStimulus(r, q, a);
    end

`ifdef CONTADOR_CICLOS_EN
    applyStimulus(1, 0, 0);
    repeat (3) runCycle();
    checkOutput("ciclos_3", ciclos, 3);
    repeat (257) runCycle();
    checkOutput("ciclos_sat", ciclos, 255);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
